// File: rtl/sprite_layer_scheduler.sv
// Per-pixel sprite compositor: scans the sprite slots in priority order, issues one
// BRAM read per in-range slot, and returns the first opaque sprite pixel or the background.
module sprite_layer_scheduler #(
  parameter int          NUM_SLOTS   = 4,
  parameter int          SPR_SIZE    = 20,
  parameter logic [17:0] TRANSPARENT = 18'h00001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [9:0]              req_x,
  input  logic [9:0]              req_y,
  input  logic [17:0]             bg_pixel,
  input  logic [NUM_SLOTS-1:0]    slot_en,
  input  logic [10*NUM_SLOTS-1:0] slot_x,
  input  logic [10*NUM_SLOTS-1:0] slot_y,
  input  logic [2*NUM_SLOTS-1:0]  slot_dir,
  output logic                    rom_en,
  output logic [1:0]              rom_sel,
  output logic [9:0]              rom_x,
  output logic [9:0]              rom_y,
  output logic [1:0]              rom_dir,
  input  logic [17:0]             rom_data,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [17:0]             pix_data,
  output logic                    pix_is_sprite,
  output logic [1:0]              pix_slot
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, OUT} state_t;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          scan_idx;
  logic [9:0]                x_q, y_q;
  logic [17:0]               bg_q;
  logic [NUM_SLOTS-1:0]      en_q;
  logic [10*NUM_SLOTS-1:0]   sx_q, sy_q;
  logic [2*NUM_SLOTS-1:0]    dir_q;
  logic                      issued_en;
  logic [1:0]                issued_sel;
  logic [9:0]                rom_x_q, rom_y_q;
  logic [1:0]                rom_sel_q, rom_dir_q;

  logic [9:0]  cur_sx, cur_sy;
  logic [10:0] dx, dy;
  logic        in_range, scanning, last_slot, cap_hit;
  logic [9:0]  scan_x, scan_y;
  logic [1:0]  scan_sel, scan_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_slot = (scan_idx == IDX_W'(NUM_SLOTS - 1));

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    pix_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = SCAN;
      end
      SCAN:  if (last_slot) state_next = DRAIN;
      DRAIN: state_next = OUT;
      OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Differences are 11 bits wide so a sprite near x=1023 never wraps onto low coordinates.
  assign cur_sx   = sx_q[int'(scan_idx)*10 +: 10];
  assign cur_sy   = sy_q[int'(scan_idx)*10 +: 10];
  assign dx       = {1'b0, x_q} - {1'b0, cur_sx};
  assign dy       = {1'b0, y_q} - {1'b0, cur_sy};
  assign in_range = en_q[scan_idx] && (x_q >= cur_sx) && (dx < 11'(SPR_SIZE))
                                   && (y_q >= cur_sy) && (dy < 11'(SPR_SIZE));

  assign scanning = (state == SCAN);
  assign scan_x   = in_range ? dx[9:0] : 10'(SPR_SIZE);
  assign scan_y   = in_range ? dy[9:0] : 10'(SPR_SIZE);
  assign scan_sel = 2'(scan_idx);
  assign scan_dir = dir_q[int'(scan_idx)*2 +: 2];

  assign rom_en  = scanning && in_range;
  assign rom_x   = scanning ? scan_x   : rom_x_q;
  assign rom_y   = scanning ? scan_y   : rom_y_q;
  assign rom_sel = scanning ? scan_sel : rom_sel_q;
  assign rom_dir = scanning ? scan_dir : rom_dir_q;

  // A read issued last cycle is a hit only if it was a real read and the pixel is opaque.
  assign cap_hit = issued_en && (rom_data != TRANSPARENT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bg_q          <= '0;
      en_q          <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      dir_q         <= '0;
      issued_en     <= 1'b0;
      issued_sel    <= '0;
      rom_x_q       <= '0;
      rom_y_q       <= '0;
      rom_sel_q     <= '0;
      rom_dir_q     <= '0;
      pix_data      <= '0;
      pix_is_sprite <= 1'b0;
      pix_slot      <= '0;
    end else begin
      issued_en  <= rom_en;
      issued_sel <= rom_sel;
      if (state == IDLE && req_valid) begin
        x_q           <= req_x;
        y_q           <= req_y;
        bg_q          <= bg_pixel;
        en_q          <= slot_en;
        sx_q          <= slot_x;
        sy_q          <= slot_y;
        dir_q         <= slot_dir;
        scan_idx      <= '0;
        pix_data      <= bg_pixel;
        pix_is_sprite <= 1'b0;
        pix_slot      <= '0;
      end
      if (scanning) begin
        scan_idx  <= scan_idx + 1'b1;
        rom_x_q   <= scan_x;
        rom_y_q   <= scan_y;
        rom_sel_q <= scan_sel;
        rom_dir_q <= scan_dir;
      end
      // The first opaque capture wins; pix_is_sprite locks out later slots.
      if (cap_hit && !pix_is_sprite) begin
        pix_data      <= rom_data;
        pix_is_sprite <= 1'b1;
        pix_slot      <= issued_sel;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed vector bench for sprite_layer_scheduler with a one-cycle-latency sprite ROM model.
module tb_sprite_layer_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [9:0]  req_x, req_y;
  logic [17:0] bg_pixel;
  logic [3:0]  slot_en;
  logic [39:0] slot_x, slot_y;
  logic [7:0]  slot_dir;
  logic        rom_en;
  logic [1:0]  rom_sel, rom_dir;
  logic [9:0]  rom_x, rom_y;
  logic [17:0] rom_data;
  logic        pix_valid, pix_ready, pix_is_sprite;
  logic [17:0] pix_data;
  logic [1:0]  pix_slot;

  logic [71:0] cur_words;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_layer_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .bg_pixel(bg_pixel), .slot_en(slot_en),
    .slot_x(slot_x), .slot_y(slot_y), .slot_dir(slot_dir),
    .rom_en(rom_en), .rom_sel(rom_sel), .rom_x(rom_x), .rom_y(rom_y), .rom_dir(rom_dir),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_is_sprite(pix_is_sprite), .pix_slot(pix_slot)
  );

  // Sprite BRAM model: the slot's word when a read is issued, an opaque junk code otherwise.
  always @(posedge clk) rom_data <= rom_en ? cur_words[int'(rom_sel)*18 +: 18] : 18'h3FFFF;

  typedef struct {
    string       name;
    logic [9:0]  rx, ry;
    logic [17:0] bg;
    logic [3:0]  en;
    logic [39:0] sx, sy;
    logic [7:0]  dir;
    logic [71:0] words;
    logic [17:0] exp_data;
    logic        exp_spr;
    logic [1:0]  exp_slot;
    logic [3:0]  exp_mask;
    logic [1:0]  f_sel;
    logic [9:0]  f_rx, f_ry;
    logic [1:0]  f_dir;
    logic        scramble;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [39:0] p10(input logic [9:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [71:0] p18(input logic [17:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [7:0] p2(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(
    input string nm, input logic [9:0] rx, ry, input logic [17:0] bg, input logic [3:0] en,
    input logic [39:0] sx, sy, input logic [7:0] dir, input logic [71:0] words,
    input logic [17:0] ed, input logic es, input logic [1:0] eslot, input logic [3:0] emask,
    input logic [1:0] fsel, input logic [9:0] frx, fry, input logic [1:0] fdir, input logic scr);
    vec_t v;
    v.name = nm; v.rx = rx; v.ry = ry; v.bg = bg; v.en = en; v.sx = sx; v.sy = sy;
    v.dir = dir; v.words = words; v.exp_data = ed; v.exp_spr = es; v.exp_slot = eslot;
    v.exp_mask = emask; v.f_sel = fsel; v.f_rx = frx; v.f_ry = fry; v.f_dir = fdir;
    v.scramble = scr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge and follow it to completion.
  task automatic apply(input vec_t v, input int hold);
    int       lat = 0, ready_in_flight = 0, late_rom = 0, stable = 0;
    logic [3:0] mask = '0;
    logic     got_first = 1'b0;
    logic [1:0] f_sel = '0, f_dir = '0;
    logic [9:0] f_rx = '0, f_ry = '0;
    req_x = v.rx; req_y = v.ry; bg_pixel = v.bg; slot_en = v.en;
    slot_x = v.sx; slot_y = v.sy; slot_dir = v.dir; cur_words = v.words;
    req_valid = 1'b1; pix_ready = 1'b0;
    #1 check({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.scramble) begin
      req_x = '0; req_y = '0; bg_pixel = '0; slot_en = '1;
      slot_x = '0; slot_y = '0; slot_dir = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      if (req_ready) ready_in_flight++;
      if (rom_en) begin
        mask[rom_sel] = 1'b1;
        if (c > 4) late_rom++;
        if (!got_first) begin
          got_first = 1'b1; f_sel = rom_sel; f_rx = rom_x; f_ry = rom_y; f_dir = rom_dir;
        end
      end
      if (pix_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({v.name, ".latency"}, 32'(lat), 32'd6);
    check({v.name, ".pix_data"}, 32'(pix_data), 32'(v.exp_data));
    check({v.name, ".is_sprite"}, 32'(pix_is_sprite), 32'(v.exp_spr));
    check({v.name, ".pix_slot"}, 32'(pix_slot), 32'(v.exp_slot));
    check({v.name, ".read_mask"}, 32'(mask), 32'(v.exp_mask));
    check({v.name, ".ready_busy"}, 32'(ready_in_flight), 32'd0);
    check({v.name, ".rom_outside_scan"}, 32'(late_rom), 32'd0);
    if (v.exp_mask != 4'd0)
      check({v.name, ".first_read"}, {8'h0, f_sel, f_dir, f_rx, f_ry},
            {8'h0, v.f_sel, v.f_dir, v.f_rx, v.f_ry});
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (pix_valid && !req_ready && pix_data == v.exp_data &&
            pix_is_sprite == v.exp_spr && pix_slot == v.exp_slot) stable++;
      end
      check({v.name, ".hold_stable"}, 32'(stable), 32'(hold));
    end
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    check({v.name, ".back_to_idle"}, {30'h0, pix_valid, req_ready}, 32'b01);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; pix_ready = 1'b0;
    req_x = '0; req_y = '0; bg_pixel = '0; slot_en = '0;
    slot_x = '0; slot_y = '0; slot_dir = '0; cur_words = '0;

    vecs[0] = mk("no_sprites", 50, 60, 18'h2AAAA, 4'b0000, p10(45, 45, 45, 45), p10(55, 55, 55, 55),
                 p2(1, 2, 3, 0), p18(18'h11111, 18'h22222, 18'h33333, 18'h00444),
                 18'h2AAAA, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[1] = mk("single_hit", 45, 52, 18'h00ABC, 4'b0100, p10(0, 0, 40, 0), p10(0, 0, 50, 0),
                 p2(0, 0, 3, 0), p18(18'h0, 18'h0, 18'h15555, 18'h0),
                 18'h15555, 1, 2, 4'b0100, 2, 5, 2, 3, 0);
    vecs[2] = mk("overlap_prio", 100, 100, 18'h00100, 4'b1010, p10(0, 90, 0, 100), p10(0, 95, 0, 100),
                 p2(0, 1, 0, 2), p18(18'h0, 18'h0F0F0, 18'h0, 18'h33333),
                 18'h0F0F0, 1, 1, 4'b1010, 1, 10, 5, 1, 0);
    vecs[3] = mk("overlap_transp", 100, 100, 18'h00100, 4'b1010, p10(0, 90, 0, 100), p10(0, 95, 0, 100),
                 p2(0, 1, 0, 2), p18(18'h0, 18'h00001, 18'h0, 18'h33333),
                 18'h33333, 1, 3, 4'b1010, 1, 10, 5, 1, 0);
    vecs[4] = mk("edge_in", 29, 29, 18'h00555, 4'b0001, p10(10, 0, 0, 0), p10(10, 0, 0, 0),
                 p2(2, 0, 0, 0), p18(18'h12345, 18'h0, 18'h0, 18'h0),
                 18'h12345, 1, 0, 4'b0001, 0, 19, 19, 2, 0);
    vecs[5] = mk("edge_x_past", 30, 10, 18'h00777, 4'b0001, p10(10, 0, 0, 0), p10(10, 0, 0, 0),
                 p2(2, 0, 0, 0), p18(18'h12345, 18'h0, 18'h0, 18'h0),
                 18'h00777, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[6] = mk("edge_x_before", 9, 10, 18'h00778, 4'b0001, p10(10, 0, 0, 0), p10(10, 0, 0, 0),
                 p2(2, 0, 0, 0), p18(18'h12345, 18'h0, 18'h0, 18'h0),
                 18'h00778, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[7] = mk("no_wrap", 3, 0, 18'h00999, 4'b0010, p10(0, 1015, 0, 0), p10(0, 0, 0, 0),
                 p2(0, 1, 0, 0), p18(18'h0, 18'h2BEEF, 18'h0, 18'h0),
                 18'h00999, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    vecs[8] = mk("all_slots_latched", 210, 305, 18'h01234, 4'b1111,
                 p10(200, 200, 200, 200), p10(300, 300, 300, 300), p2(0, 1, 2, 3),
                 p18(18'h00001, 18'h00001, 18'h2ABCD, 18'h3CCCC),
                 18'h2ABCD, 1, 2, 4'b1111, 0, 10, 5, 0, 1);
    vecs[9] = mk("edge_y_zero_word", 0, 20, 18'h00321, 4'b1100, p10(0, 0, 0, 0), p10(0, 0, 1, 0),
                 p2(0, 0, 1, 0), p18(18'h0, 18'h0, 18'h00000, 18'h3AAAA),
                 18'h00000, 1, 2, 4'b0100, 2, 0, 19, 1, 0);

    repeat (2) @(negedge clk);
    check("reset.ready_valid", {30'h0, req_ready, pix_valid}, 32'b10);
    check("reset.pix", {12'h0, pix_is_sprite, pix_slot, pix_data}, 32'h0);
    check("reset.rom", {7'h0, rom_en, rom_sel, rom_dir, rom_x, rom_y}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], 0);

    apply(vecs[1], 10);

    // Abort a pixel two cycles into SCAN, then request again right after release.
    req_x = vecs[2].rx; req_y = vecs[2].ry; bg_pixel = vecs[2].bg; slot_en = vecs[2].en;
    slot_x = vecs[2].sx; slot_y = vecs[2].sy; slot_dir = vecs[2].dir; cur_words = vecs[2].words;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("midscan_reset.outputs",
             {req_ready, pix_valid, rom_en, pix_is_sprite, 10'h0, pix_data}, {4'b1000, 28'h0});
    @(negedge clk);
    reset = 1'b0;
    apply(vecs[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
